// File: rtl/mac_tcdm_responder.sv
// Multi-port TCDM slave: round-robin arbitration of MP ports onto one word-addressed
// memory, one access per cycle, with a fixed LAT-cycle response pipeline.
package mac_tcdm_responder_pkg;
    typedef struct packed {
        logic busy;
    } flags_t;
endpackage

module mac_tcdm_responder
    import mac_tcdm_responder_pkg::*;
#(
    parameter int unsigned MP    = 4,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [MP-1:0]       tcdm_req_i,
    output logic [MP-1:0]       tcdm_gnt_o,
    input  logic [MP-1:0][31:0] tcdm_add_i,
    input  logic [MP-1:0]       tcdm_wen_i,
    input  logic [MP-1:0][3:0]  tcdm_be_i,
    input  logic [MP-1:0][31:0] tcdm_data_i,
    output logic [MP-1:0][31:0] tcdm_r_data_o,
    output logic [MP-1:0]       tcdm_r_valid_o,
    output flags_t              flags_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;

    logic [PW-1:0]          r_rr;
    logic                   w_arb_en;
    logic                   w_found;
    logic                   w_hit;
    logic [PW-1:0]          w_sel;
    logic [PW-1:0]          w_cand;
    logic [AW-1:0]          w_widx;
    logic [31:0]            w_wmask;
    logic [31:0]            w_rd_word;
    logic [31:0]            r_mem [DEPTH];
    logic [LAT-1:0]         r_pv;
    logic [LAT-1:0][PW-1:0] r_pid;
    logic [LAT-1:0][31:0]   r_pdata;
    logic                   w_unused_add;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Reset also blocks grants so no handshake completes while the state is being cleared.
    assign w_arb_en     = enable_i & ~clear_i & rst_ni;
    assign w_unused_add = ^tcdm_add_i;

    // Round-robin search: first requester at or above r_rr, wrapping modulo MP.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < MP; i++) begin
            w_cand = PW'((32'(r_rr) + i) % MP);
            if (!w_found && tcdm_req_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end else begin
                w_sel   = w_sel;
            end
        end
        w_hit = w_found & w_arb_en;
    end

    assign tcdm_gnt_o = w_hit ? (MP'(1'b1) << w_sel) : '0;
    assign w_widx     = tcdm_add_i[w_sel][AW+1:2];
    assign w_wmask    = be_to_mask(tcdm_be_i[w_sel]);
    // Writes land on the grant edge, so a read granted next cycle already sees them.
    assign w_rd_word  = (w_hit && tcdm_wen_i[w_sel]) ? r_mem[w_widx] : 32'h0;

    // Arbitration pointer: advances past the granted port, cleared by soft clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (clear_i) begin
            r_rr <= '0;
        end else if (w_hit) begin
            r_rr <= (w_sel == PW'(MP - 1)) ? '0 : w_sel + PW'(1);
        end else begin
            r_rr <= r_rr;
        end
    end

    // Memory array: byte-masked write on the grant edge; contents survive soft clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem <= '{default: 32'h0};
        end else if (w_hit && !tcdm_wen_i[w_sel]) begin
            r_mem[w_widx] <= (r_mem[w_widx] & ~w_wmask) | (tcdm_data_i[w_sel] & w_wmask);
        end else begin
            r_mem <= r_mem;
        end
    end

    // Response pipeline: bit/lane 0 is the newest grant, lane LAT-1 drives the ports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pv    <= '0;
            r_pid   <= '0;
            r_pdata <= '0;
        end else if (clear_i) begin
            r_pv    <= '0;
            r_pid   <= '0;
            r_pdata <= '0;
        end else begin
            r_pv    <= LAT'({r_pv, w_hit});
            r_pid   <= (LAT*PW)'({r_pid, w_sel});
            r_pdata <= (LAT*32)'({r_pdata, w_rd_word});
        end
    end

    // Response fan-out; a clear in the delivery cycle suppresses the response too.
    always_comb begin
        tcdm_r_valid_o = '0;
        tcdm_r_data_o  = '0;
        if (r_pv[LAT-1] && !clear_i) begin
            tcdm_r_valid_o[r_pid[LAT-1]] = 1'b1;
            tcdm_r_data_o[r_pid[LAT-1]]  = r_pdata[LAT-1];
        end else begin
            tcdm_r_valid_o = '0;
        end
    end

    assign flags_o.busy = |r_pv;

endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Bench for mac_tcdm_responder: three instances (LAT = 1, 2, 3) share one stimulus and
// are compared each cycle against a per-cycle grant-history model.
module tb_mac_tcdm_responder;
    import mac_tcdm_responder_pkg::*;

    localparam int MP    = 4;
    localparam int DEPTH = 1024;
    localparam int NL    = 3;
    localparam int HMAX  = 4096;
    localparam int SW    = 2 * MP + 32 * MP + 1;
    localparam int OW    = NL * SW;

    logic                clk = 1'b0;
    logic                rst_n, clear, enable;
    logic [MP-1:0]       req, wen;
    logic [MP-1:0][31:0] add, data;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0]       gnt    [NL];
    logic [MP-1:0]       rvalid [NL];
    logic [MP-1:0][31:0] rdata  [NL];
    flags_t              flags  [NL];

    // model state: grant history indexed by cycle, per-instance validity
    int                  cyc, rr_m, g_m;
    logic [31:0]         mem_m [DEPTH];
    bit                  hv    [NL][HMAX];
    int                  hport [HMAX];
    logic [31:0]         hdata [HMAX];
    logic [OW-1:0]       exp_v;
    int                  n_checks, n_errors;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NL; k++) begin : g_dut
        mac_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LAT(k + 1)) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .clear_i       (clear),
            .enable_i      (enable),
            .tcdm_req_i    (req),
            .tcdm_gnt_o    (gnt[k]),
            .tcdm_add_i    (add),
            .tcdm_wen_i    (wen),
            .tcdm_be_i     (be),
            .tcdm_data_i   (data),
            .tcdm_r_data_o (rdata[k]),
            .tcdm_r_valid_o(rvalid[k]),
            .flags_o       (flags[k])
        );
    end

    function automatic logic [OW-1:0] observe();
        logic [OW-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) v = {v[OW-SW-1:0], gnt[k], rvalid[k], rdata[k], flags[k].busy};
        return v;
    endfunction

    task automatic model_reset();
        mem_m = '{default: 32'h0};
        hv    = '{default: 1'b0};
        rr_m  = 0;
    endtask

    task automatic model_eval();
        logic [MP-1:0]       eg, erv;
        logic [MP-1:0][31:0] erd;
        logic                eb;
        int                  lat;
        exp_v = '0;
        g_m   = -1;
        if (rst_n && enable && !clear)
            for (int i = 0; i < MP; i++)
                if (g_m < 0 && req[(rr_m + i) % MP]) g_m = (rr_m + i) % MP;
        eg = (g_m >= 0) ? (4'b0001 << g_m) : 4'b0000;
        for (int k = 0; k < NL; k++) begin
            lat = k + 1;
            erv = '0;
            erd = '0;
            eb  = 1'b0;
            if (cyc >= lat && hv[k][cyc-lat] && !clear) begin
                erv[hport[cyc-lat]] = 1'b1;
                erd[hport[cyc-lat]] = hdata[cyc-lat];
            end
            for (int d = 1; d <= lat; d++) if (cyc >= d && hv[k][cyc-d]) eb = 1'b1;
            exp_v = {exp_v[OW-SW-1:0], eg, erv, erd, eb};
        end
    endtask

    task automatic model_commit();
        int w;
        if (g_m >= 0) begin
            w = int'(add[g_m] >> 2) % DEPTH;
            if (wen[g_m]) begin
                hdata[cyc] = mem_m[w];
            end else begin
                for (int b = 0; b < 4; b++) if (be[g_m][b]) mem_m[w][8*b +: 8] = data[g_m][8*b +: 8];
                hdata[cyc] = 32'h0;
            end
            hport[cyc] = g_m;
            for (int k = 0; k < NL; k++) hv[k][cyc] = 1'b1;
            rr_m = (g_m + 1) % MP;
        end else begin
            for (int k = 0; k < NL; k++) hv[k][cyc] = 1'b0;
        end
        if (rst_n && clear) begin
            rr_m = 0;
            for (int k = 0; k < NL; k++)
                for (int d = 0; d <= k + 1; d++) if (cyc - d >= 0) hv[k][cyc-d] = 1'b0;
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        req = '0; wen = '0; be = '0; add = '0; data = '0;
    endtask

    task automatic put(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
        req[p] = 1'b1; add[p] = a; wen[p] = w; be[p] = b; data[p] = d;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c == 2) rst_n = 1'b1;
            if (c <= 2) put(0, 32'h40, 1'b1, 4'hF, 32'h0);
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            if (c == 2) begin
                n_checks++;
                if (gnt[0] !== 4'b0001) begin
                    n_errors++;
                    $display("FAIL reset_gnt got=%b exp=0001", gnt[0]);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (rvalid[0] !== 4'b0001 || rdata[0][0] !== 32'h0) begin
                    n_errors++;
                    $display("FAIL reset_read rvalid=%b r_data=%h exp 0001/00000000", rvalid[0], rdata[0][0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read_be();
        for (int c = 0; c < 9; c++) begin
            idle();
            case (c)
                0:       put(3, 32'h10, 1'b0, 4'b1111, 32'hDEADBEEF);
                1:       put(3, 32'h10, 1'b0, 4'b0001, 32'h00000011);
                2:       put(0, 32'h10, 1'b1, 4'b1111, 32'h0);
                3:       put(2, 32'h10, 1'b0, 4'b0000, 32'hFFFFFFFF);
                4:       put(1, 32'h10, 1'b1, 4'b1111, 32'h0);
                default: idle();
            endcase
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL write_read cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            if (c == 3 || c == 5) begin
                n_checks++;
                if (rdata[0][(c == 3) ? 0 : 1] !== 32'hDEADBE11) begin
                    n_errors++;
                    $display("FAIL be_read c=%0d r_data=%h exp=deadbe11", c, rdata[0][(c == 3) ? 0 : 1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [MP-1:0] want;
        for (int c = 0; c < 18; c++) begin
            idle();
            clear = (c == 0);
            want  = 4'b0000;
            if (c >= 1 && c <= 8) begin
                for (int p = 0; p < MP; p++) put(p, 32'(p * 4), 1'b1, 4'hF, 32'h0);
                want = 4'b0001 << ((c - 1) % 4);
            end else if (c >= 9 && c <= 11) begin
                put(2, 32'h8, 1'b1, 4'hF, 32'h0);
                want = 4'b0100;
            end else if (c == 12 || c == 13) begin
                put(1, 32'h4, 1'b1, 4'hF, 32'h0);
                put(3, 32'hC, 1'b1, 4'hF, 32'h0);
                want = (c == 12) ? 4'b1000 : 4'b0010;
            end
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL round_robin cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            n_checks++;
            if (gnt[1] !== want) begin
                n_errors++;
                $display("FAIL rr_order c=%0d gnt=%b exp=%b", c, gnt[1], want);
            end
            tick();
        end
        clear = 1'b0;
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 8; c++) begin
            idle();
            case (c)
                0:       put(1, 32'h1000, 1'b0, 4'hF, 32'hA5A5A5A5);
                1:       put(1, 32'h0, 1'b1, 4'hF, 32'h0);
                2:       put(2, 32'h3, 1'b1, 4'hF, 32'h0);
                3:       put(0, 32'hABCDE000, 1'b1, 4'hF, 32'h0);
                default: idle();
            endcase
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            if (c >= 2 && c <= 4) begin
                n_checks++;
                if (rdata[0][(c == 4) ? 0 : c - 1] !== 32'hA5A5A5A5) begin
                    n_errors++;
                    $display("FAIL wrap_read c=%0d r_data=%h exp=a5a5a5a5", c, rdata[0][(c == 4) ? 0 : c - 1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_clear_enable();
        for (int c = 0; c < 16; c++) begin
            idle();
            clear  = (c == 2);
            enable = !((c == 6) || (c == 7) || (c >= 10 && c <= 13));
            case (c)
                0:          put(0, 32'h10, 1'b1, 4'hF, 32'h0);
                1:          put(0, 32'h0, 1'b1, 4'hF, 32'h0);
                2:          put(3, 32'h20, 1'b1, 4'hF, 32'h0);
                6, 7, 8:    put(2, 32'h10, 1'b1, 4'hF, 32'h0);
                9:          put(0, 32'h10, 1'b1, 4'hF, 32'h0);
                default:    idle();
            endcase
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL clear_enable cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            if (c == 2) begin
                n_checks++;
                if (gnt[0] !== 4'b0000 || rvalid[0] !== 4'b0000 || rvalid[1] !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL clear_cycle gnt=%b rv1=%b rv2=%b exp all 0", gnt[0], rvalid[0], rvalid[1]);
                end
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if (flags[2].busy !== 1'b0 || rvalid[2] !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL clear_flush c=%0d busy=%b rv=%b exp 0/0000", c, flags[2].busy, rvalid[2]);
                end
            end
            if (c >= 6 && c <= 8) begin
                n_checks++;
                if (gnt[0] !== ((c == 8) ? 4'b0100 : 4'b0000)) begin
                    n_errors++;
                    $display("FAIL enable_gnt c=%0d gnt=%b", c, gnt[0]);
                end
            end
            if (c == 12) begin
                n_checks++;
                if (rvalid[2] !== 4'b0001) begin
                    n_errors++;
                    $display("FAIL enable_drain rv=%b exp=0001", rvalid[2]);
                end
            end
            tick();
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 2) begin
                #2;
                rst_n = 1'b0;
                model_reset();
            end
            if (c == 4) rst_n = 1'b1;
            if (c == 0) put(1, 32'h14, 1'b0, 4'hF, 32'h12345678);
            if (c == 1 || c == 7) put(1, 32'h14, 1'b1, 4'hF, 32'h0);
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL async_reset cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            if (c >= 2 && c <= 6) begin
                n_checks++;
                if (rvalid[0] !== 4'b0000 || rvalid[1] !== 4'b0000 || rvalid[2] !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL reset_drop c=%0d rv=%b %b %b exp none", c, rvalid[0], rvalid[1], rvalid[2]);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (rvalid[0] !== 4'b0010 || rdata[0][1] !== 32'h0) begin
                    n_errors++;
                    $display("FAIL reset_mem rv=%b r_data=%h exp 0010/00000000", rvalid[0], rdata[0][1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 404; c++) begin
            idle();
            clear  = 1'b0;
            enable = 1'b1;
            if (c < 400) begin
                enable = ($urandom_range(0, 9) != 0);
                clear  = ($urandom_range(0, 19) == 0);
                for (int p = 0; p < MP; p++) begin
                    req[p]  = ($urandom_range(0, 3) != 0);
                    add[p]  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                    wen[p]  = 1'($urandom_range(0, 1));
                    be[p]   = 4'($urandom);
                    data[p] = $urandom;
                end
            end
            sample();
            n_checks++;
            if (observe() !== exp_v) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observe(), exp_v);
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        g_m      = -1;
        rst_n    = 1'b1;
        clear    = 1'b0;
        enable   = 1'b1;
        idle();
        #1;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_write_read_be();
        test_round_robin();
        test_wrap();
        test_clear_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_tcdm_responder.md
# mac_tcdm_responder

Multi-port TCDM slave that answers the `hwpe_stream_intf_tcdm` master ports driven by the MAC streamer: it serves the a/b/c source reads and the d sink writes. It arbitrates the ports round-robin onto a single word-addressed memory, one access per cycle. It returns responses after a fixed latency. It is used as the memory end of the MAC engine in block-level benches and as a small private scratchpad in integration.

## Interface
- `MP`, 4, number of TCDM slave ports.
- `DEPTH`, 1024, memory size in 32-bit words; power of two.
- `LAT`, 1, grant-to-`r_valid` latency in cycles; LAT ≥ 1.
- `clk_i`  in  1  single clock; everything is sampled on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  synchronous soft clear.
- `enable_i`  in  1  when low, no grants are issued.
- `tcdm[MP-1:0]`  slave  MP × `hwpe_stream_intf_tcdm`. Per port:
  - `req`  in  1
  - `gnt`  out  1
  - `add`  in  32  byte address
  - `wen`  in  1  1 = read, 0 = write
  - `be`  in  4  byte enables
  - `data`  in  32  write data
  - `r_data`  out  32  read data
  - `r_valid`  out  1  response valid
- `flags_o.busy`  out  1  a response is pending in the pipeline.

## Operation
- Word index = `add[$clog2(DEPTH)+1:2]`.
  - `add[1:0]` and all higher bits are ignored, so addresses wrap modulo DEPTH×4.
- Arbitration:
  - Round-robin pointer `rr`, reset value 0.
  - Each cycle, when `enable_i`=1 and `clear_i`=0, grant the first port with `req`=1 searching from `rr` upward, modulo MP.
  - At most one `gnt` is high per cycle.
  - After a grant to port k, `rr` ← (k+1) mod MP. Without a grant, `rr` holds.
- Write (`wen`=0): on the grant edge, update only the bytes whose `be` bit is 1. `be`=0000 leaves memory unchanged but still produces a response.
- Read (`wen`=1): memory is read in the grant cycle. The data is carried through a LAT-stage pipeline together with the port id.
- Response:
  - Every granted transaction, read or write, raises `r_valid` on its own port exactly LAT cycles after the grant, for one cycle.
  - `r_data` holds the read word for reads and 0 for writes.
  - On all other ports and cycles, `r_valid`=0 and `r_data`=0.
- Ordering: reads and writes to the same address complete in grant order.
  - A read granted in the cycle after a write to the same word returns the new data.
  - The memory write completes on the grant edge, so no bypass is needed.
- `clear_i`=1:
  - No grants.
  - `rr` ← 0.
  - All pipeline stages are invalidated; pending `r_valid` pulses are dropped.
  - Memory contents are retained.
- `enable_i`=0:
  - No grants.
  - The pipeline keeps draining; responses already in flight are still delivered.
- Requests are not latched. A port whose `req` is not granted must hold `req`, `add`, `wen`, `be` and `data` until `gnt`; the responder imposes no timeout.

## Timing
- `gnt` is combinational from `req`, `rr`, `enable_i` and `clear_i` in the same cycle (standard TCDM handshake). There is no path from `gnt` back to `req`.
- Throughput: one transaction per cycle in aggregate.
- A port that is requesting alone is granted every cycle.
- With all MP ports requesting continuously, each port is granted once every MP cycles.
- Fixed grant-to-`r_valid` latency of LAT cycles; there is no backpressure on responses.
- `flags_o.busy` = OR of the pipeline stage valid bits.
- Reset values (`rst_ni`=0, asynchronous):
  - all `gnt`, `r_valid`, `r_data` and `flags_o.busy` = 0;
  - `rr` = 0;
  - pipeline valid bits = 0;
  - memory = all zeros.
- Reset asserted mid-transaction drops all pending responses immediately. No `r_valid` appears after reset release unless a new grant occurs.
- Simultaneous `clear_i` and `req`: no grant that cycle, and the response already due that cycle is also suppressed.

## Test plan
- **Reset and basic read.** After reset, port 0 reads `add`=0x40 → `gnt` in the same cycle; `r_valid` LAT=1 cycle later with `r_data`=0x00000000.
- **Write then read, byte enables.**
  - Port 3 writes 0xDEADBEEF to 0x10 with `be`=1111, then 0x00000011 with `be`=0001.
  - Port 0 then reads 0x10 → 0xDEADBE11.
  - A back-to-back read in the cycle right after the write returns the new value.
- **Round-robin.**
  - All 4 ports hold `req` for 8 cycles → grant order 0,1,2,3,0,1,2,3.
  - Then only port 2 requests → it is granted every cycle.
  - Then ports 1 and 3 request → 3 is granted first (rr=3), then 1.
- **Wrap-around.** With DEPTH=1024, write 0xA5A5A5A5 to `add`=0x1000 → a read of `add`=0x0 returns 0xA5A5A5A5.
- **Clear and enable.**
  - With LAT=3, grant 2 reads, then assert `clear_i` → no `r_valid` appears and `flags_o.busy` drops the next cycle.
  - With `enable_i`=0, `req` is held and `gnt` stays 0; raising `enable_i` grants in that cycle.
- **Async reset mid-stream.** Drop `rst_ni` between a grant and its `r_valid` (LAT=2) → the response never appears and the memory reads back 0.
